// File: rtl/mcm_rx_frame_pkg.sv
// ---------------------------------------------------------------------------
// mcm_rx_frame_pkg: shared state encoding, default sizes and the timer width helper. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mcm_rx_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RECV = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int MCM_RX_BYTES_DEF = 16;
  localparam int MCM_TIMEOUT_DEF  = 800;

  // A counter that must hold TIMEOUT-1 needs clog2(TIMEOUT) bits, never fewer than one.
  function automatic int timer_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mcm_rx_bank.sv
// ---------------------------------------------------------------------------
// mcm_rx_bank: two-bank byte store with one write port and a registered read port. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mcm_rx_bank
  import mcm_rx_frame_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_bank_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [7:0]        wr_data_i,
  input  logic              we_i,
  input  logic              rd_bank_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              re_i,
  output logic [7:0]        rd_data_o
);

  localparam int c_depth = 2 << ADDR_W;

  logic [7:0] mem_q [c_depth];
  logic [7:0] rd_data_q;

  // Storage carries no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    rd_data_q <= '0;
    else if (re_i) rd_data_q <= mem_q[{rd_bank_i, rd_addr_i}];
  end

  assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/mcm_rx_frame.sv
// ---------------------------------------------------------------------------
// mcm_rx_frame: captures MCM UART replies into a ping-pong buffer read by the packer. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mcm_rx_frame
  import mcm_rx_frame_pkg::*;
#(
  parameter int RX_BYTES = MCM_RX_BYTES_DEF,
  parameter int TIMEOUT  = MCM_TIMEOUT_DEF,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iRQ,
  input  logic              iVal,
  input  logic [7:0]        iData,
  input  logic [ADDR_W-1:0] iRdAddr,
  input  logic              iRdEn,
  output logic [7:0]        oRdData,
  output logic [ADDR_W-1:0] oWrAddr,
  output logic              oDone,
  output logic              oTimeout,
  output logic [ADDR_W-1:0] oCount,
  output logic              oBank,
  output logic              oBusy
);

  localparam int                c_tw    = timer_width(TIMEOUT);
  localparam logic [c_tw-1:0]   c_tmax  = c_tw'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(RX_BYTES - 1);
  localparam logic [ADDR_W-1:0] c_count = ADDR_W'(RX_BYTES);
  localparam logic [ADDR_W:0]   c_limit = (ADDR_W + 1)'(RX_BYTES);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [c_tw-1:0]   timer_q, timer_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              rd_bank_q, rd_bank_d;
  logic              done_q, done_d;
  logic              tmo_q, tmo_d;
  logic              rq_meta_q, rq_sync_q, rq_prev_q, rq_pulse_q;
  logic              oor_q;
  logic              wr_en;
  logic              timer_exp;
  logic [7:0]        bank_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rq_meta_q  <= 1'b0;
      rq_sync_q  <= 1'b0;
      rq_prev_q  <= 1'b0;
      rq_pulse_q <= 1'b0;
    end else begin
      rq_meta_q  <= iRQ;
      rq_sync_q  <= rq_meta_q;
      rq_prev_q  <= rq_sync_q;
      rq_pulse_q <= rq_sync_q & ~rq_prev_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      timer_q   <= '0;
      count_q   <= '0;
      rd_bank_q <= 1'b1;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
      oor_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      count_q   <= count_d;
      rd_bank_q <= rd_bank_d;
      done_q    <= done_d;
      tmo_q     <= tmo_d;
      if (iRdEn) oor_q <= ({1'b0, iRdAddr} >= c_limit);
    end
  end

  assign timer_exp = (timer_q == c_tmax);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    count_d   = count_q;
    rd_bank_d = rd_bank_q;
    done_d    = 1'b0;
    tmo_d     = 1'b0;
    wr_en     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rq_pulse_q) begin
          state_d = ST_WAIT;
          idx_d   = '0;
          timer_d = '0;
        end
      end
      ST_WAIT, ST_RECV: begin
        // A fresh request outranks a byte, which outranks the timer.
        if (rq_pulse_q) begin
          state_d = ST_WAIT;
          idx_d   = '0;
          timer_d = '0;
        end else if (iVal) begin
          wr_en   = 1'b1;
          idx_d   = idx_q + 1'b1;
          timer_d = '0;
          if (idx_q == c_last) begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            rd_bank_d = ~rd_bank_q;
            count_d   = c_count;
          end else begin
            state_d = ST_RECV;
          end
        end else if (timer_exp) begin
          state_d = ST_IDLE;
          tmo_d   = 1'b1;
          idx_d   = '0;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = rq_pulse_q ? ST_WAIT : ST_IDLE;
        idx_d   = '0;
        timer_d = '0;
      end
    endcase
  end

  mcm_rx_bank #(
    .ADDR_W(ADDR_W)
  ) u_bank (
    .clk       (clk),
    .reset     (reset),
    .wr_bank_i (~rd_bank_q),
    .wr_addr_i (idx_q),
    .wr_data_i (iData),
    .we_i      (wr_en),
    .rd_bank_i (rd_bank_q),
    .rd_addr_i (iRdAddr),
    .re_i      (iRdEn),
    .rd_data_o (bank_rdata)
  );

  assign oRdData  = oor_q ? 8'h00 : bank_rdata;
  assign oWrAddr  = idx_q;
  assign oDone    = done_q;
  assign oTimeout = tmo_q;
  assign oCount   = count_q;
  assign oBank    = rd_bank_q;
  assign oBusy    = (state_q != ST_IDLE);

endmodule

`default_nettype wire
